// File: rtl/audio_spi_tx_if.sv
// rtl/audio_spi_tx_if.sv - word handshake between an audio source and audio_spi_tx
interface audio_spi_tx_if #(
  parameter int DATA_W = 16
);
  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
endinterface

// File: rtl/audio_spi_tx.sv
// rtl/audio_spi_tx.sv - buffered 16-bit SPI transmitter (mode 0, active-high CS)
// All pins are a one-cycle registered decode of the FSM, so every phase keeps its length.
module audio_spi_tx #(
  parameter int DATA_W     = 16,
  parameter int CLK_DIV    = 6,
  parameter int CS_SETUP   = 2,
  parameter int CS_HOLD    = 2,
  parameter int IDLE_GAP   = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_25mhz,
  input  logic                          reset,
  audio_spi_tx_if.slave                 tx,
  output logic                          spi_sclk_out,
  output logic                          spi_mosi_out,
  output logic                          spi_cs_out,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(DATA_W);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic              phase_q, phase_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [AW:0]       count_q, count_d;
  logic              tx_ready_q, sclk_q, mosi_q, cs_q, busy_q;
  logic              push, pop;

  assign push = tx.tx_valid && tx_ready_q;
  assign pop  = (state_q == IDLE) && (count_q != '0);

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_25mhz) begin
    if (push) mem[wr_ptr_q] <= tx.tx_data;
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    phase_d = phase_q;
    shreg_d = shreg_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          shreg_d = mem[rd_ptr_q];
          cnt_d   = '0;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (cnt_q == 8'(CS_SETUP - 1)) begin
          cnt_d   = '0;
          phase_d = 1'b0;
          bit_d   = '0;
          state_d = SHIFT;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SHIFT: begin
        // phase_q low = SCLK low half; data advances only when a high half ends
        if (cnt_q == 8'(CLK_DIV - 1)) begin
          cnt_d = '0;
          if (!phase_q) begin
            phase_d = 1'b1;
          end else begin
            phase_d = 1'b0;
            if (bit_q == BW'(DATA_W - 1)) begin
              state_d = HOLD;
            end else begin
              bit_d   = bit_q + 1'b1;
              shreg_d = {shreg_q[DATA_W-2:0], 1'b0};
            end
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HOLD: begin
        if (cnt_q == 8'(CS_HOLD - 1)) begin
          cnt_d   = '0;
          state_d = GAP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      GAP: begin
        if (cnt_q == 8'(IDLE_GAP - 1)) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_25mhz or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      phase_q    <= 1'b0;
      shreg_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      tx_ready_q <= 1'b0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cs_q       <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      phase_q    <= phase_d;
      shreg_q    <= shreg_d;
      wr_ptr_q   <= push ? wr_ptr_q + 1'b1 : wr_ptr_q;
      rd_ptr_q   <= pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
      count_q    <= count_d;
      tx_ready_q <= (count_d != (AW+1)'(FIFO_DEPTH));
      sclk_q     <= (state_q == SHIFT) && phase_q;
      cs_q       <= (state_q == SETUP) || (state_q == SHIFT) || (state_q == HOLD);
      mosi_q     <= ((state_q == SETUP) || (state_q == SHIFT) || (state_q == HOLD))
                    ? shreg_q[DATA_W-1] : 1'b0;
      busy_q     <= (state_q != IDLE) || (count_q != '0);
    end
  end

  assign tx.tx_ready  = tx_ready_q;
  assign spi_sclk_out = sclk_q;
  assign spi_mosi_out = mosi_q;
  assign spi_cs_out   = cs_q;
  assign busy         = busy_q;
  assign fifo_level   = count_q;
endmodule

// File: tb/tb_audio_spi_tx.sv
// tb/tb_audio_spi_tx.sv - scoreboard bench for audio_spi_tx
module tb_audio_spi_tx;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rst_sw = 1'b1;
  logic [15:0] sw_data = 16'h0;
  logic sw_valid = 1'b0;
  always #20 clk = ~clk;

  audio_spi_tx_if #(.DATA_W(16)) tx_if ();
  logic sclk, mosi, cs, busy;
  logic [2:0] level;

  audio_spi_tx #(.DATA_W(16), .CLK_DIV(6), .CS_SETUP(2), .CS_HOLD(2), .IDLE_GAP(2), .FIFO_DEPTH(4)) dut (
    .clk_25mhz(clk), .reset(reset), .tx(tx_if.slave),
    .spi_sclk_out(sclk), .spi_mosi_out(mosi), .spi_cs_out(cs), .busy(busy), .fifo_level(level)
  );

  int n_cmp = 0, n_fail = 0;
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  logic [15:0] exp_q[$];
  int width = 0, nrise = 0, gap = 0, frames = 0;
  int stray_sclk = 0, mosi_glitch = 0, ready_bad = 0, max_level = 0;
  logic [15:0] rx = 16'h0;
  logic prev_cs = 0, prev_sclk = 0, prev_mosi = 0, in_frame = 0, have_fall = 0, gap_busy = 0;

  always @(negedge clk) begin
    if (reset) begin
      in_frame = 0; have_fall = 0; prev_cs = 0; prev_sclk = 0; prev_mosi = 0;
    end else begin
      if (tx_if.tx_ready !== (level != 3'd4)) ready_bad++;
      if (int'(level) > max_level) max_level = int'(level);
      if (sclk && !prev_sclk && !cs) stray_sclk++;
      if (sclk && prev_sclk && mosi !== prev_mosi) mosi_glitch++;
      if (cs && !prev_cs) begin
        if (have_fall && gap_busy) check("cs_gap", gap, 3);
        in_frame = 1; width = 0; nrise = 0; rx = 16'h0; frames++;
      end
      if (!cs && prev_cs) begin
        if (exp_q.size() == 0) check("unexpected_frame", rx, 32'hFFFF_FFFF);
        else check("frame_data", rx, exp_q.pop_front());
        check("frame_rises", nrise, 16);
        check("cs_width", width, 196);
        in_frame = 0; have_fall = 1; gap = 0; gap_busy = 1;
      end
      if (cs) width++;
      else begin
        gap++;
        if (!busy) gap_busy = 0;
      end
      if (in_frame && sclk && !prev_sclk) begin
        nrise++;
        rx = {rx[14:0], mosi};
      end
      prev_cs = cs; prev_sclk = sclk; prev_mosi = mosi;
    end
  end

  for (genvar g = 0; g < 2; g++) begin : sw
    localparam int CD = (g == 0) ? 1 : 12;
    audio_spi_tx_if #(.DATA_W(16)) s_if ();
    logic s_sclk, s_mosi, s_cs, s_busy;
    logic [2:0] s_level;
    int frames = 0, width = 0, nrise = 0;
    logic [15:0] rx = 16'h0;
    logic p_cs = 0, p_sclk = 0;
    assign s_if.tx_data  = sw_data;
    assign s_if.tx_valid = sw_valid;
    audio_spi_tx #(.DATA_W(16), .CLK_DIV(CD)) u_dut (
      .clk_25mhz(clk), .reset(rst_sw), .tx(s_if.slave),
      .spi_sclk_out(s_sclk), .spi_mosi_out(s_mosi), .spi_cs_out(s_cs), .busy(s_busy), .fifo_level(s_level)
    );
    always @(negedge clk) begin
      if (!rst_sw) begin
        if (s_cs && !p_cs) begin width = 0; nrise = 0; rx = 16'h0; end
        if (!s_cs && p_cs) begin
          frames++;
          check($sformatf("sweep%0d_width", CD), width, 4 + 32 * CD);
          check($sformatf("sweep%0d_rises", CD), nrise, 16);
          check($sformatf("sweep%0d_data", CD), rx, 16'h1234);
        end
        if (s_cs) width++;
        if (s_cs && s_sclk && !p_sclk) begin nrise++; rx = {rx[14:0], s_mosi}; end
        p_cs = s_cs; p_sclk = s_sclk;
      end
    end
  end

  task automatic send(input logic [15:0] w);
    int t;
    for (t = 0; t < 2000; t++) begin
      tx_if.tx_valid = 1'b1;
      tx_if.tx_data  = w;
      if (tx_if.tx_ready) break;
      @(negedge clk);
    end
    check("send_accept", t < 2000, 1);
    exp_q.push_back(w);
    @(negedge clk);
  endtask

  task automatic wait_cs_low(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!cs) break;
    end
    check("wait_cs_fall", i < budget, 1);
  endtask

  task automatic wait_idle(input int budget);
    int i;
    for (i = 0; i < budget; i++) begin
      @(negedge clk);
      if (!busy && exp_q.size() == 0) break;
    end
    check("wait_idle", i < budget, 1);
  endtask

  logic [15:0] burst_w [4] = '{16'h0001, 16'h8000, 16'hFFFF, 16'h0000};
  logic [15:0] full_w [10] = '{16'h1111, 16'h2222, 16'h3333, 16'h4444, 16'h5555,
                               16'h6666, 16'h7777, 16'h8888, 16'h9999, 16'hAAAA};
  int f0;
  int i7;

  initial begin
    tx_if.tx_valid = 1'b0;
    tx_if.tx_data  = 16'h0;
    repeat (3) @(negedge clk);
    check("reset_outputs", {sclk, mosi, cs, busy, level, tx_if.tx_ready}, 0);
    #2 reset = 1'b0; rst_sw = 1'b0;
    @(negedge clk);
    check("ready_after_reset", tx_if.tx_ready, 1);
    check("level_after_reset", level, 0);

    tx_if.tx_data = 16'hC0DE; tx_if.tx_valid = 1'b1; exp_q.push_back(16'hC0DE);
    sw_data = 16'h1234; sw_valid = 1'b1;
    @(negedge clk);
    tx_if.tx_valid = 1'b0; tx_if.tx_data = 16'hFFFF; sw_valid = 1'b0; sw_data = 16'hEEEE;
    check("lat_edge_n", cs, 0);
    check("level_one", level, 1);
    @(negedge clk);
    check("lat_edge_n1", cs, 0);
    @(negedge clk);
    check("lat_edge_n2", cs, 1);
    wait_cs_low(400);
    @(negedge clk);
    check("busy_fall_plus1", busy, 1);
    @(negedge clk);
    check("busy_fall_plus2", busy, 0);
    wait_idle(100);

    max_level = 0; f0 = frames;
    foreach (burst_w[k]) send(burst_w[k]);
    tx_if.tx_valid = 1'b0;
    wait_idle(1200);
    check("burst_level_ge3", max_level >= 3, 1);
    check("burst_frames", frames - f0, 4);

    max_level = 0; f0 = frames;
    foreach (full_w[k]) send(full_w[k]);
    tx_if.tx_valid = 1'b0;
    wait_idle(3000);
    check("full_max_level", max_level, 4);
    check("full_frames", frames - f0, 10);

    send(16'hA5A5);
    send(16'h1111);
    tx_if.tx_valid = 1'b0;
    for (i7 = 0; i7 < 600; i7++) begin
      @(negedge clk);
      if (in_frame && nrise >= 7) break;
    end
    check("wait_rise7", i7 < 600, 1);
    #2 reset = 1'b1;
    #1 check("midreset_outputs", {sclk, mosi, cs, busy, level, tx_if.tx_ready}, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    f0 = frames;
    #2 reset = 1'b0;
    @(negedge clk);
    check("midreset_level", level, 0);
    check("midreset_ready", tx_if.tx_ready, 1);
    check("midreset_busy", busy, 0);
    repeat (300) @(negedge clk);
    check("midreset_no_frame", frames - f0, 0);

    check("stray_sclk", stray_sclk, 0);
    check("mosi_high_glitch", mosi_glitch, 0);
    check("ready_vs_level", ready_bad, 0);
    check("sweep1_frames", sw[0].frames, 1);
    check("sweep12_frames", sw[1].frames, 1);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/audio_spi_tx.md
AUDIO_SPI_TX -- requirements
Module: audio_spi_tx

Interface
REQ-001 Parameter DATA_W, default 16: word width, fixed 16 for the audio path.
REQ-002 Parameter CLK_DIV, default 6: SCLK half-period in clk_25mhz cycles (about 2.08 MHz SCLK); legal range 1..255.
REQ-003 Parameter CS_SETUP, default 2: clk cycles from CS assertion to the first SCLK rise window (start of first low phase); legal range 1..15.
REQ-004 Parameter CS_HOLD, default 2: clk cycles from the last SCLK fall to CS deassertion; legal range 1..15.
REQ-005 Parameter IDLE_GAP, default 2: minimum clk cycles CS stays low between frames; legal range 1..15.
REQ-006 Parameter FIFO_DEPTH, default 4: input buffer depth in words; power of two, minimum 2.
REQ-007 clk_25mhz  input  1  system clock; one clock, all logic on its rising edge.
REQ-008 reset  input  1  asynchronous, active-high reset.
REQ-009 tx_data  input  DATA_W  word to transmit.
REQ-010 tx_valid  input  1  tx_data is valid this cycle.
REQ-011 tx_ready  output  1  FIFO can accept a word (not full).
REQ-012 spi_sclk_out  output  1  SPI clock; idles low.
REQ-013 spi_mosi_out  output  1  serial data, MSB first.
REQ-014 spi_cs_out  output  1  chip select, active-high, framing exactly one word.
REQ-015 busy  output  1  high while a frame is in progress or the FIFO is non-empty.
REQ-016 fifo_level  output  $clog2(FIFO_DEPTH)+1  words currently buffered.

Function
REQ-017 The block SHALL accept a word on any rising edge where tx_valid and tx_ready are both high; tx_ready SHALL equal (fifo_level != FIFO_DEPTH).
REQ-018 The block SHALL use the FSM states IDLE, SETUP, SHIFT, HOLD, and GAP.
REQ-019 IDLE: when the FIFO is non-empty, the block SHALL pop the head word into a 16-bit shift register, drive spi_cs_out=1 and spi_mosi_out=bit15, and go to SETUP; otherwise it stays in IDLE.
REQ-020 SETUP: the block SHALL hold spi_sclk_out=0 for CS_SETUP cycles, then go to SHIFT.
REQ-021 SHIFT: each bit SHALL occupy CLK_DIV cycles with SCLK low followed by CLK_DIV cycles with SCLK high.
REQ-022 SHIFT: spi_mosi_out SHALL change only on the SCLK falling edge and SHALL be stable throughout each high phase, so a receiver samples on the SCLK rise.
REQ-023 After the 16th high phase, SCLK SHALL return low and the FSM SHALL go to HOLD; each frame SHALL contain exactly 16 SCLK rising edges.
REQ-024 HOLD: the block SHALL keep spi_cs_out=1 for CS_HOLD cycles.
REQ-025 On leaving HOLD, spi_cs_out SHALL fall and the FSM SHALL go to GAP for IDLE_GAP cycles, then to IDLE.
REQ-026 spi_cs_out SHALL be high for exactly CS_SETUP+32*CLK_DIV+CS_HOLD cycles per frame (196 with the defaults).
REQ-027 Latency: for a word accepted at edge N into an empty FIFO with the FSM in IDLE, spi_cs_out SHALL rise at edge N+1 plus one registered cycle, i.e. be observed high after edge N+2.
REQ-028 Back-to-back frames: words queued in the FIFO SHALL be sent in FIFO order with exactly IDLE_GAP+1 cycles of CS low between frames.
REQ-029 Simultaneous push and pop SHALL leave fifo_level unchanged and preserve word order.
REQ-030 A push while full SHALL never occur, because tx_ready is low.
REQ-031 The FIFO read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-032 tx_valid deasserting mid-frame SHALL not affect a frame in progress.
REQ-033 The transmitted word SHALL be latched at pop; later changes to tx_data SHALL not alter it.
REQ-034 All outputs SHALL be registered, with no combinational path from tx_valid to the SPI pins.

Reset
REQ-035 While reset is high, the block SHALL immediately force spi_sclk_out=0, spi_mosi_out=0, spi_cs_out=0, busy=0, fifo_level=0, tx_ready=0, FSM=IDLE, FIFO pointers=0, and clear all counters.
REQ-036 A reset asserted mid-frame SHALL abort the frame, discard all buffered words, and produce no further SCLK edges.
REQ-037 tx_ready SHALL rise on the first clk_25mhz edge after reset deasserts.

Verification
REQ-038 Single word: push 16'hC0DE after reset -> one CS pulse of 196 cycles, 16 SCLK rises, MOSI sampled at each rise = 1100_0000_1101_1110, busy low 2 cycles after CS falls.
REQ-039 Burst: push 16'h0001, 16'h8000, 16'hFFFF, 16'h0000 on consecutive cycles -> FIFO reaches level 3-4, tx_ready never violated, 4 frames in order, CS low exactly 3 cycles between frames.
REQ-040 Full: hold tx_valid high with FIFO_DEPTH=4 -> tx_ready low at level 4, rises the cycle after a pop, no word lost or duplicated over 10 words.
REQ-041 Mid-frame reset: assert reset after the 7th SCLK rise of 16'hA5A5 -> all outputs 0 within the same cycle, no SCLK rise after reset, FIFO empty after release.
REQ-042 Loopback: drive the existing Pico-side SPI receiver in the top level from spi_sclk_out/spi_mosi_out/spi_cs_out with 16'hC0DE -> receiver data_is_ready pulses once and its output word equals 16'hC0DE.
REQ-043 Parameter sweep: CLK_DIV=1 and CLK_DIV=12 with 16'h1234 -> CS width = 4+32*CLK_DIV cycles, data correct.
